// File: rtl/ram_copy_engine.sv
// ram_copy_engine
//   Word-copy DMA master for the 2 KiB byte-addressed RAM (8 banks x 256 B,
//   big-endian words, registered read data). On start it reads word_count
//   32-bit words from src_addr and writes them to dst_addr in ascending order,
//   one word every three cycles (read, capture, write).
//
//   Optional feature macro: CHECKSUM_EN adds a 32-bit running sum of every
//   word read during the transfer.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active low
//   start        in   transfer request, sampled only in IDLE
//   src_addr     in   [10:0] source byte address (word aligned)
//   dst_addr     in   [10:0] destination byte address (word aligned)
//   word_count   in   [9:0]  number of words, 0..512
//   busy         out  high in RD, CAP, WR
//   done         out  one-cycle pulse at the end of every accepted start
//   error        out  sticky command-rejected flag, cleared by next start
//   ram_writeEn  out  RAM write enable
//   ram_addy     out  [10:0] RAM byte address
//   ram_wdata    out  [31:0] RAM write data
//   ram_rdata    in   [31:0] RAM read data, valid one cycle after address
//   checksum     out  [31:0] sum of copied words (CHECKSUM_EN only)
//
// state | meaning
// IDLE  | waiting for start
// RD    | present source address to the RAM
// CAP   | RAM read data valid; capture it
// WR    | write captured word to destination, advance pointers
// DONE  | one-cycle completion pulse

module ram_copy_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] src_addr,
    input  logic [10:0] dst_addr,
    input  logic [9:0]  word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ram_writeEn,
    output logic [10:0] ram_addy,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
`ifdef CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state, state_nxt;

    logic [10:0] cur_src;
    logic [10:0] cur_dst;
    logic [9:0]  remaining;
    logic [31:0] data_q;
    logic [10:0] addy_q;
    logic [31:0] wdata_q;

    // End addresses evaluated at 13 bits so 4*1023 + 2047 cannot wrap.
    logic [12:0] src_end;
    logic [12:0] dst_end;
    logic        cmd_bad;

    assign src_end = {2'b00, src_addr} + {1'b0, word_count, 2'b00};
    assign dst_end = {2'b00, dst_addr} + {1'b0, word_count, 2'b00};
    assign cmd_bad = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) ||
                     (src_end > 13'd2048) || (dst_end > 13'd2048);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cmd_bad || (word_count == 10'd0)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = S_WR;
            S_WR:   state_nxt = (remaining == 10'd1) ? S_DONE : S_RD;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outside RD/CAP/WR the RAM port holds whatever it last drove, which is
    // tracked by addy_q/wdata_q.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        ram_writeEn = 1'b0;
        ram_addy    = addy_q;
        ram_wdata   = wdata_q;
        case (state)
            S_RD, S_CAP: begin
                busy     = 1'b1;
                ram_addy = cur_src;
            end
            S_WR: begin
                busy        = 1'b1;
                ram_writeEn = 1'b1;
                ram_addy    = cur_dst;
                ram_wdata   = data_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
            data_q    <= '0;
            addy_q    <= '0;
            wdata_q   <= '0;
            error     <= 1'b0;
        end else begin
            addy_q  <= ram_addy;
            wdata_q <= ram_wdata;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_src   <= src_addr;
                        cur_dst   <= dst_addr;
                        remaining <= word_count;
                        error     <= cmd_bad;
                    end
                end
                S_CAP: begin
                    data_q <= ram_rdata;
                end
                S_WR: begin
                    cur_src   <= cur_src + 11'd4;
                    cur_dst   <= cur_dst + 11'd4;
                    remaining <= remaining - 10'd1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum <= '0;
        end else if ((state == S_IDLE) && start) begin
            checksum <= '0;
        end else if (state == S_CAP) begin
            checksum <= checksum + ram_rdata;
        end
    end
`endif

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Word-copy DMA master that drives the 2 KiB byte-addressed RAM (8 banks × 256 bytes, big-endian word access, registered read data) from the initiator side. On a start command it reads a block of 32-bit words from a source address and writes them to a destination address. It is the RAM's only requester during a transfer. It sits between the control logic (start/status) and the RAM's clk/writeEn/addy/dataIn/dataOut port.

## Interface
- No parameters; RAM geometry is fixed at 11-bit byte address and 32-bit data.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  the single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; state is cleared on a clk edge while rst=0.
- start  in  1  transfer request; sampled only in IDLE.
- src_addr  in  11  source byte address; must be word-aligned.
- dst_addr  in  11  destination byte address; must be word-aligned.
- word_count  in  10  number of 32-bit words to copy, 0..512.
- busy  out  1  high while in RD, CAP or WR.
- done  out  1  one-cycle pulse at the end of every accepted start, including zero-length and error cases.
- error  out  1  sticky; set on a rejected command; cleared when the next start is accepted.
- ram_writeEn  out  1  drives the RAM writeEn input.
- ram_addy  out  11  drives the RAM addy input.
- ram_wdata  out  32  drives the RAM dataIn input.
- ram_rdata  in  32  connects to the RAM dataOut output; valid one cycle after a read address is presented.
- checksum  out  32  present only with CHECKSUM_EN.

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE, start=1: latch src/dst/count and clear error.
  - Misaligned address (src_addr[1:0]≠0 or dst_addr[1:0]≠0): set error, go to DONE.
  - Out of range (src_addr+4·word_count>2048 or dst_addr+4·word_count>2048, evaluated at 13 bits): set error, go to DONE.
  - word_count=0: go to DONE.
  - Otherwise go to RD.
- RD: ram_addy=cur_src, ram_writeEn=0; go to CAP.
- CAP: ram_addy holds cur_src, ram_writeEn=0; latch ram_rdata into the data register; go to WR.
- WR: ram_addy=cur_dst, ram_wdata=data register, ram_writeEn=1.
  - cur_src+=4, cur_dst+=4, remaining-=1.
  - If remaining reaches 0, go to DONE; else go to RD.
- DONE: done=1 for one cycle; go to IDLE.
- Aligned addresses keep every word inside one bank (offset ≤252), so no bank-crossing write is ever issued.
- Copy order is ascending. Overlapping ranges with dst>src copy already-overwritten data; this is the defined behaviour, with no overlap protection.
- start outside IDLE is ignored; it is not queued.
- ram_writeEn is high only in WR. In all other states it is 0, and ram_addy/ram_wdata hold their last values.

## Timing
- Reset values: state=IDLE, busy=0, done=0, error=0, ram_writeEn=0, ram_addy=0, ram_wdata=0, checksum=0.
- Reset mid-transfer takes effect at that edge: ram_writeEn=0 the following cycle. The partial copy is left as is and done is not pulsed.
- Valid transfer, start sampled at edge 0:
  - Word k RD in cycle 3k+1, CAP in 3k+2, WR in 3k+3.
  - done in cycle 3N+1.
  - busy high in cycles 1..3N.
- Error or zero-length start at edge 0: done in cycle 1 and busy stays 0; error is visible from cycle 1.
- Throughput is 3 cycles per word; a maximum transfer of 512 words takes 1537 cycles from start to done.
- A new start may be sampled in the cycle after done.

## Configuration
- CHECKSUM_EN:
  - Defined: add a 32-bit checksum output. It is cleared on an accepted start and adds each captured word in CAP (modulo 2^32). It is stable from the done cycle until the next accepted start.
  - Undefined: no checksum port and no adder; all other behaviour is identical.

## Test plan
- src=0x000, dst=0x400, count=4, RAM preloaded with 0x11111111..0x44444444 → dst words match; done in cycle 13; 4 writeEn pulses; checksum=0xAAAAAAAA.
- src=0x0F8, dst=0x1F8, count=4 (crosses bank 0→1 and 1→2) → all 4 words copied; no write at offset >252.
- count=0 → done in cycle 1; error=0; no RAM access.
- src=0x002 → error=1, done in cycle 1, no writeEn. Next valid start clears error.
- dst=0x7F0, count=5 (needs 0x804 bytes of range) → error=1, no writeEn. dst=0x7F0, count=4 → accepted and completes.
- rst=0 during WR of word 2 of 8 → ram_writeEn=0 next cycle, IDLE, no done. start pulsed mid-transfer → ignored.
